// File: rtl/missile_sched_pkg.sv
// Shared game constants, coordinate type and missile slot state encoding.
package game_pkg;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned X_MIN   = 150;
  localparam int unsigned X_MAX   = 800;
  localparam int unsigned Y_TOP   = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    S_IDLE,
    S_FLY
  } slot_state_e;
endpackage

// File: rtl/missile_sched_if.sv
// Bundle between tank/button logic, the missile scheduler and collision/draw consumers.
interface missile_sched_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    import game_pkg::*;

    logic                           tick;
    logic                           fire;
    coord_t                         xpos_tank;
    coord_t                         ypos_tank;
    logic [NUM_SLOTS-1:0]           hit;
    logic [NUM_SLOTS-1:0]           active;
    logic [COORD_W*NUM_SLOTS-1:0]   xpos_m;
    logic [COORD_W*NUM_SLOTS-1:0]   ypos_m;
    logic                           fire_ack;
    logic                           cooldown_busy;

    modport master (
        output tick, fire, xpos_tank, ypos_tank, hit,
        input  active, xpos_m, ypos_m, fire_ack, cooldown_busy
    );

    modport slave (
        input  tick, fire, xpos_tank, ypos_tank, hit,
        output active, xpos_m, ypos_m, fire_ack, cooldown_busy
    );
endinterface

// File: rtl/missile_sched_slot.sv
// One missile slot: idle until allocated, then climbs SPEED pixels per tick until it leaves or is hit.
module missile_slot #(
    parameter int unsigned SPEED = 4,
    parameter int unsigned Y_TOP = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  game_pkg::coord_t spawn_x,
    input  game_pkg::coord_t spawn_y,
    input  logic            tick,
    input  logic            hit,
    output logic            active,
    output game_pkg::coord_t x,
    output game_pkg::coord_t y
);
    import game_pkg::*;

    slot_state_e state, state_next;
    coord_t      x_next, y_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
        end
    end

    // Hit outranks motion; an idle slot ignores tick/hit, so a fresh allocation does too.
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        case (state)
            S_IDLE: begin
                if (alloc) begin
                    state_next = S_FLY;
                    x_next     = spawn_x;
                    y_next     = spawn_y;
                end
            end
            S_FLY: begin
                if (hit) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (y < COORD_W'(Y_TOP + SPEED))
                        state_next = S_IDLE;
                    else
                        y_next = y - COORD_W'(SPEED);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign active = (state == S_FLY);
endmodule

// File: rtl/missile_sched.sv
// Missile slot pool: fire request detect, lowest-free-slot allocation and shot cooldown.
// Define MISSILE_AUTOFIRE_EN to treat a held fire button as a repeating request.
module missile_sched #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned COOLDOWN  = 20,
    parameter int unsigned SPEED     = 4,
    parameter int unsigned SPAWN_OFF = 16,
    parameter int unsigned Y_TOP     = game_pkg::Y_TOP
) (
    input logic            clk,
    input logic            rst,
    missile_sched_if.slave bus
);
    import game_pkg::*;

    localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic                         req;
    logic                         accept;
    logic                         any_free;
    logic [NUM_SLOTS-1:0]         act;
    logic [NUM_SLOTS-1:0]         pick;
    logic [NUM_SLOTS-1:0]         alloc;
    logic [CW-1:0]                cnt;
    logic                         fire_ack;
    coord_t                       spawn_y;
    coord_t                       xs [NUM_SLOTS];
    coord_t                       ys [NUM_SLOTS];
    logic [COORD_W*NUM_SLOTS-1:0] xm, ym;

`ifdef MISSILE_AUTOFIRE_EN
    assign req = bus.fire;
`else
    logic fire_q;

    // Resets high so a button held through reset does not produce a shot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fire_q <= 1'b1;
        else     fire_q <= bus.fire;
    end

    assign req = bus.fire & ~fire_q;
`endif

    always_comb begin
        if (bus.ypos_tank < COORD_W'(SPAWN_OFF + Y_TOP))
            spawn_y = COORD_W'(Y_TOP);
        else
            spawn_y = bus.ypos_tank - COORD_W'(SPAWN_OFF);
    end

    always_comb begin
        pick     = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!act[i] && !any_free) begin
                pick[i]  = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    assign accept = req & any_free & (cnt == '0);
    assign alloc  = accept ? pick : '0;

    // Reload on a shot wins over a coincident tick decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            fire_ack <= 1'b0;
        end else begin
            fire_ack <= accept;
            if (accept)
                cnt <= CW'(COOLDOWN);
            else if (bus.tick && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        missile_slot #(
            .SPEED (SPEED),
            .Y_TOP (Y_TOP)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .alloc   (alloc[i]),
            .spawn_x (bus.xpos_tank),
            .spawn_y (spawn_y),
            .tick    (bus.tick),
            .hit     (bus.hit[i]),
            .active  (act[i]),
            .x       (xs[i]),
            .y       (ys[i])
        );
    end

    always_comb begin
        xm = '0;
        ym = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            xm[COORD_W*i +: COORD_W] = xs[i];
            ym[COORD_W*i +: COORD_W] = ys[i];
        end
    end

    assign bus.active        = act;
    assign bus.xpos_m        = xm;
    assign bus.ypos_m        = ym;
    assign bus.fire_ack      = fire_ack;
    assign bus.cooldown_busy = (cnt != '0);
endmodule

// File: tb/tb_missile_sched.sv
// Self-checking bench for missile_sched: directed scenarios plus random traffic against a slot-pool model.
module tb_missile_sched;
    import game_pkg::*;

    localparam int NS   = 4;
    localparam int CD   = 20;
    localparam int SPD  = 4;
    localparam int SOFF = 16;
    localparam int YT   = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    missile_sched_if #(.NUM_SLOTS(NS)) bus ();

    missile_sched #(
        .NUM_SLOTS (NS),
        .COOLDOWN  (CD),
        .SPEED     (SPD),
        .SPAWN_OFF (SOFF),
        .Y_TOP     (YT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference pool: plain per-slot flags and integer coordinates.
    bit m_act [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_cd;
    bit m_fq;
    bit m_ack;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cd  = 0;
        m_fq  = 1;
        m_ack = 0;
    endfunction

    function automatic void model_step(bit f, bit t, logic [NS-1:0] h, int xt, int yt);
        bit req;
        bit acc;
        int k = -1;
`ifdef MISSILE_AUTOFIRE_EN
        req = f;
`else
        req = f && !m_fq;
`endif
        for (int i = 0; i < NS; i++)
            if (!m_act[i] && k < 0) k = i;
        acc = req && (m_cd == 0) && (k >= 0);
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (h[i]) m_act[i] = 0;
                else if (t) begin
                    if (m_y[i] < YT + SPD) m_act[i] = 0;
                    else m_y[i] = m_y[i] - SPD;
                end
            end
        end
        if (acc) begin
            m_act[k] = 1;
            m_x[k]   = xt;
            m_y[k]   = (yt < SOFF + YT) ? YT : yt - SOFF;
        end
        if (acc) m_cd = CD;
        else if (t && m_cd > 0) m_cd = m_cd - 1;
        m_ack = acc;
        m_fq  = f;
    endfunction

    function automatic logic [NS-1:0] e_act();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [10*NS-1:0] e_x();
        logic [10*NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [10*NS-1:0] e_y();
        logic [10*NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(m_y[i]);
        return v;
    endfunction

    // One clock: drive on the falling edge, advance the model, sample 1ns after the rising edge.
    task automatic cycle(input bit f, input bit t, input logic [NS-1:0] h);
        @(negedge clk);
        bus.fire = f;
        bus.tick = t;
        bus.hit  = h;
        model_step(f, t, h, int'(bus.xpos_tank), int'(bus.ypos_tank));
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, '0);
            cycle(0, 0, '0);
        end
    endtask

    task automatic do_reset(input bit f);
        @(negedge clk);
        rst      = 1'b1;
        bus.fire = f;
        bus.tick = 1'b0;
        bus.hit  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic shoot();
        cycle(0, 0, '0);
        cycle(1, 0, '0);
    endtask

    task automatic test_reset();
        bus.xpos_tank = 10'd450;
        bus.ypos_tank = 10'd450;
        do_reset(0);
        n_checks++;
        if (bus.active !== '0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", bus.active); end
        n_checks++;
        if (bus.xpos_m !== '0 || bus.ypos_m !== '0) begin
            n_fail++; $display("FAIL reset_pos: got x=%h y=%h expected 0", bus.xpos_m, bus.ypos_m);
        end
        n_checks++;
        if (bus.fire_ack !== 1'b0 || bus.cooldown_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ack=%b busy=%b expected 0 0", bus.fire_ack, bus.cooldown_busy);
        end
    endtask

    task automatic test_first_shot();
        do_reset(0);
        shoot();
        n_checks++;
        if (bus.active !== 4'b0001) begin n_fail++; $display("FAIL first_active: got %b expected 0001", bus.active); end
        n_checks++;
        if (bus.xpos_m[9:0] !== 10'd450 || bus.ypos_m[9:0] !== 10'd434) begin
            n_fail++; $display("FAIL first_pos: got (%0d,%0d) expected (450,434)", bus.xpos_m[9:0], bus.ypos_m[9:0]);
        end
        n_checks++;
        if (bus.fire_ack !== 1'b1 || bus.cooldown_busy !== 1'b1) begin
            n_fail++; $display("FAIL first_flags: got ack=%b busy=%b expected 1 1", bus.fire_ack, bus.cooldown_busy);
        end
        cycle(1, 0, '0);
        n_checks++;
        if (bus.fire_ack !== 1'b0) begin n_fail++; $display("FAIL first_ack_pulse: got %b expected 0", bus.fire_ack); end
    endtask

    task automatic test_hold_fire();
        int acks = 0;
        do_reset(0);
        cycle(0, 0, '0);
        for (int i = 0; i < 60; i++) begin
            cycle(1, (i % 2) == 0, '0);
            if (bus.fire_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL hold_fire_shots: got %0d expected 1", acks); end
        cycle(0, 0, '0);
    endtask

    task automatic test_spacing_and_full();
        logic [NS-1:0] want [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        do_reset(0);
        shoot();
        ticks(5);
        cycle(1, 0, '0);
        n_checks++;
        if (bus.fire_ack !== 1'b0 || bus.active !== 4'b0001) begin
            n_fail++; $display("FAIL cooldown_drop: got ack=%b active=%b expected 0 0001", bus.fire_ack, bus.active);
        end
        cycle(0, 0, '0);
        ticks(16);
        for (int s = 1; s < 4; s++) begin
            shoot();
            n_checks++;
            if (bus.fire_ack !== 1'b1 || bus.active !== want[s]) begin
                n_fail++; $display("FAIL spaced_shot%0d: got ack=%b active=%b expected 1 %b", s, bus.fire_ack, bus.active, want[s]);
            end
            ticks(21);
        end
        shoot();
        n_checks++;
        if (bus.fire_ack !== 1'b0 || bus.active !== 4'b1111 || bus.cooldown_busy !== 1'b0) begin
            n_fail++; $display("FAIL full_drop: got ack=%b active=%b busy=%b expected 0 1111 0", bus.fire_ack, bus.active, bus.cooldown_busy);
        end
        n_checks++;
        if (bus.ypos_m !== e_y() || bus.xpos_m !== e_x()) begin
            n_fail++; $display("FAIL full_pos: got x=%h y=%h expected x=%h y=%h", bus.xpos_m, bus.ypos_m, e_x(), e_y());
        end
    endtask

    task automatic test_hit_tick();
        int y1 = m_y[1];
        int y0 = m_y[0] - SPD;
        cycle(0, 1, 4'b0010);
        n_checks++;
        if (bus.active !== 4'b1101) begin n_fail++; $display("FAIL hit_tick_active: got %b expected 1101", bus.active); end
        n_checks++;
        if (int'(bus.ypos_m[19:10]) != y1 || int'(bus.ypos_m[9:0]) != y0) begin
            n_fail++; $display("FAIL hit_tick_y: got y1=%0d y0=%0d expected %0d %0d", bus.ypos_m[19:10], bus.ypos_m[9:0], y1, y0);
        end
    endtask

    task automatic test_hit_new();
        do_reset(0);
        shoot();
        cycle(0, 0, 4'b0001);
        n_checks++;
        if (bus.active !== 4'b0000) begin n_fail++; $display("FAIL hit_new_retire: got %b expected 0000", bus.active); end
        ticks(20);
        shoot();
        n_checks++;
        if (bus.active !== 4'b0001 || bus.fire_ack !== 1'b1) begin
            n_fail++; $display("FAIL hit_new_reuse: got active=%b ack=%b expected 0001 1", bus.active, bus.fire_ack);
        end
    endtask

    task automatic test_retire_top();
        do_reset(0);
        shoot();
        ticks(106);
        n_checks++;
        if (bus.active !== 4'b0001 || bus.ypos_m[9:0] !== 10'd10) begin
            n_fail++; $display("FAIL top_last: got active=%b y=%0d expected 0001 10", bus.active, bus.ypos_m[9:0]);
        end
        cycle(0, 1, '0);
        n_checks++;
        if (bus.active !== 4'b0000 || bus.ypos_m[9:0] !== 10'd10) begin
            n_fail++; $display("FAIL top_retire: got active=%b y=%0d expected 0000 10", bus.active, bus.ypos_m[9:0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset(0);
        for (int s = 0; s < 3; s++) begin
            shoot();
            ticks(21);
        end
        n_checks++;
        if (bus.active !== 4'b0111) begin n_fail++; $display("FAIL async_pre: got %b expected 0111", bus.active); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.active !== 4'b0000 || bus.cooldown_busy !== 1'b0 || bus.ypos_m !== '0) begin
            n_fail++; $display("FAIL async_rst: got active=%b busy=%b y=%h expected 0000 0 0", bus.active, bus.cooldown_busy, bus.ypos_m);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fire_through_reset();
        int acks = 0;
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, '0);
            if (bus.fire_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0 || bus.active !== 4'b0000) begin
            n_fail++; $display("FAIL held_through_reset: got acks=%0d active=%b expected 0 0000", acks, bus.active);
        end
        cycle(0, 0, '0);
    endtask

`ifdef MISSILE_AUTOFIRE_EN
    task automatic test_autofire();
        int at [$];
        int nt = 0;
        do_reset(0);
        for (int i = 0; i < 140; i++) begin
            cycle(1, 0, '0);
            if (bus.fire_ack === 1'b1) at.push_back(nt);
            cycle(1, 1, '0);
            nt++;
            if (bus.fire_ack === 1'b1) at.push_back(nt);
        end
        n_checks++;
        if (at.size() < 4 || at[0] != 0 || at[1] != 20 || at[2] != 40 || at[3] != 60) begin
            n_fail++; $display("FAIL autofire_ticks: got %p expected 0 20 40 60", at);
        end
        cycle(0, 0, '0);
    endtask
`endif

    task automatic test_random();
        bit f = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [NS-1:0] h = '0;
            if ($urandom_range(0, 3) == 0) f = ~f;
            for (int j = 0; j < NS; j++) h[j] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.xpos_tank = 10'($urandom_range(0, 1023));
                bus.ypos_tank = 10'($urandom_range(0, 1023));
            end
            cycle(f, $urandom_range(0, 2) == 0, h);
            n_checks++;
            if (bus.active !== e_act() || bus.fire_ack !== m_ack || bus.cooldown_busy !== (m_cd != 0)) begin
                n_fail++;
                $display("FAIL rand_ctrl @%0d: got act=%b ack=%b busy=%b expected %b %b %b",
                         i, bus.active, bus.fire_ack, bus.cooldown_busy, e_act(), m_ack, (m_cd != 0));
            end
            n_checks++;
            if (bus.xpos_m !== e_x() || bus.ypos_m !== e_y()) begin
                n_fail++;
                $display("FAIL rand_pos @%0d: got x=%h y=%h expected x=%h y=%h", i, bus.xpos_m, bus.ypos_m, e_x(), e_y());
            end
        end
    endtask

    initial begin
        bus.fire      = 1'b0;
        bus.tick      = 1'b0;
        bus.hit       = '0;
        bus.xpos_tank = 10'd450;
        bus.ypos_tank = 10'd450;
        model_reset();
        test_reset();
        test_first_shot();
`ifdef MISSILE_AUTOFIRE_EN
        test_autofire();
`else
        test_hold_fire();
        test_spacing_and_full();
        test_hit_tick();
        test_hit_new();
        test_retire_top();
        test_async_reset();
        test_fire_through_reset();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
